// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encoding,
// default sizes and the shift-add-3 adjust threshold.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  // A digit at or above this value would overflow past 9 after doubling.
  localparam logic [3:0] ADJ_THRESH = 4'd5;

  // Smallest number of decimal digits able to hold 2^width-1.
  function automatic int min_digits(input int width);
    longint unsigned max_val;
    longint unsigned pow10;
    int n;
    max_val = (longint'(1) << width) - 1;
    pow10   = 1;
    n       = 0;
    while (pow10 <= max_val) begin
      pow10 = pow10 * 10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Combinational single-digit adjust for the shift-add-3 (double dabble)
// conversion: digits >= 5 get 3 added before the next left shift.
module bcd_adj3
  import bcd_conv_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= ADJ_THRESH) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock,
// fixed WIDTH-cycle latency, single-cycle done pulse.
module bcd_conv
  import bcd_conv_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_adj;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] shreg_shl;
  logic [BCD_W-1:0] scratch_shl;

  logic load;
  logic step;
  logic finish;

  // Per-digit adjust of the current scratch value.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d (scratch[4*g +: 4]),
      .q (scratch_adj[4*g +: 4])
    );
  end

  // Adjusted scratch and shift register move left as one concatenated word.
  assign scratch_shl = {scratch_adj[BCD_W-2:0], shreg[WIDTH-1]};
  assign shreg_shl   = {shreg[WIDTH-2:0], 1'b0};

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else if (load) begin
      shreg   <= bin;
      scratch <= '0;
      cnt     <= '0;
    end else if (step) begin
      shreg   <= shreg_shl;
      scratch <= scratch_shl;
      cnt     <= cnt + 1'b1;
    end
  end

  // Result and handshake outputs are registered; bcd only changes on completion.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
        bcd  <= scratch_shl;
      end
    end
  end

endmodule

// File: doc/bcd_conv.md
BCD_CONV -- requirements
Module: bcd_conv

Interface
REQ-001 Parameter WIDTH, default 16: binary input width, matching the product width of the multiplier stage.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port clr, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: request a conversion; sampled only in IDLE.
REQ-006 Port bin, input, WIDTH: unsigned binary value (multiplier product); sampled on the edge that accepts start.
REQ-007 Port bcd, output, 4*DIGITS: packed BCD result; digit 0 is in bits [3:0]; registered.
REQ-008 Port busy, output, 1: high while a conversion is in progress; registered.
REQ-009 Port done, output, 1: single-cycle pulse marking that bcd is updated; registered.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-011 IDLE with start=1 at edge N: latch bin into an internal shift register, clear the BCD scratch register and the iteration counter, go to SHIFT, and set busy=1.
REQ-012 IDLE with start=0: stay in IDLE; outputs hold.
REQ-013 Each SHIFT edge (shift-add-3 method), in this order:
- add 3 to every scratch digit whose value is >=5;
- shift {scratch, shift register} left by 1;
- increment the counter.
REQ-014 After exactly WIDTH shifts (edge N+WIDTH), copy the scratch value into bcd, set done=1 and busy=0, and go to DONE.
REQ-015 DONE SHALL last exactly one cycle; edge N+WIDTH+1 returns to IDLE with done=0.
REQ-016 Latency SHALL be fixed: done is high in the cycle after edge N+16 for WIDTH=16, independent of the value of bin.
REQ-017 start while in SHIFT or DONE SHALL be ignored; it is not queued, and changes on bin are ignored.
REQ-018 bcd SHALL hold its last result until the next completion; it SHALL NOT show intermediate scratch values.
REQ-019 Counter width SHALL be clog2(WIDTH)+1; the counter SHALL NOT wrap during a conversion.
REQ-020 Every digit of bcd SHALL be in the range 0..9 for any input, including bin = 2^WIDTH-1.
REQ-021 DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1; the default 5 covers 65535.

Reset
REQ-022 clr=1 SHALL immediately, without waiting for clk, force: state IDLE, bcd=0, busy=0, done=0, scratch, shift register and counter all 0.
REQ-023 clr asserted mid-conversion SHALL abort the conversion; no done pulse is produced for it.
REQ-024 After clr is released, the first start SHALL be accepted at the first rising edge of clk.

Structure
REQ-025 A shared package SHALL hold:
- the state encoding typedef (IDLE=0, SHIFT=1, DONE=2, 2 bits);
- WIDTH_DEF=16;
- DIGITS_DEF=5;
- the add-3 threshold constant 5.
REQ-026 One sub-module, bcd_adj3, SHALL be used: a combinational 4-bit digit adjust (d>=5 ? d+3 : d), instantiated DIGITS times.
REQ-027 The FSM, the counter and the registers SHALL reside in bcd_conv.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- bin=0, start pulse -> done after 17 edges, bcd=20'h00000.
- bin=65025 (255*255) -> bcd=20'h65025; busy high for 16 cycles.
- bin=65535 -> bcd=20'h65535; all digits <=9.
- bin=1234, start held high for 20 cycles -> exactly one conversion, bcd=20'h01234, next start accepted only from IDLE.
- bin=999, then clr pulsed at shift 8 -> no done; bcd=0, busy=0; new start with bin=42 -> bcd=20'h00042.
- start pulse in DONE cycle with a new bin -> ignored; bcd keeps prior value.
